// File: rtl/signal_edge_monitor.sv
// Edge monitor: synchronizes mon_in, timestamps each edge, measures edge intervals and queues
// event records in a 4-entry FIFO. Define SIGNAL_EDGE_MONITOR_TIMEOUT_EN to enable the stuck check.
module signal_edge_monitor #(
  parameter int unsigned TS_W        = 16,
  parameter int unsigned INT_W       = 8,
  parameter int unsigned HALF_PERIOD = 5,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mon_in,
  input  logic             enable,
  input  logic             clr_err,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic             evt_level,
  output logic [INT_W-1:0] evt_interval,
  output logic             period_err,
  output logic             overflow,
  output logic             stuck
);

  localparam int unsigned EntryW = TS_W + 1 + INT_W;
  localparam logic [INT_W-1:0] IntMax = '1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [TS_W-1:0]   ts_q;
  logic [INT_W-1:0]  cnt_q;
  logic              pend_valid_q;
  logic [TS_W-1:0]   pend_ts_q;
  logic              pend_level_q;
  logic [INT_W-1:0]  pend_interval_q;

  logic [EntryW-1:0] mem_q [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        count_q;

  logic              edge_det, active;
  logic [INT_W-1:0]  cnt_inc;
  logic              push, pop, drop, pe_set;
  logic [EntryW-1:0] head;

  assign edge_det = s2_q ^ s3_q;
  assign active   = enable && (state_q != StIdle);
  assign cnt_inc  = (cnt_q == IntMax) ? IntMax : cnt_q + INT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      ts_q <= '0;
    end else begin
      s1_q <= mon_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Detected edges are staged one cycle in pend_* before entering the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      pend_valid_q    <= 1'b0;
      pend_ts_q       <= '0;
      pend_level_q    <= 1'b0;
      pend_interval_q <= '0;
    end else begin
      pend_valid_q <= 1'b0;
      pend_ts_q    <= ts_q;
      pend_level_q <= s2_q;
      if (!enable) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StArm;
            cnt_q   <= '0;
          end
          StArm: begin
            if (edge_det) begin
              state_q         <= StMeasure;
              cnt_q           <= '0;
              pend_valid_q    <= 1'b1;
              pend_interval_q <= '0;
            end
          end
          StMeasure: begin
            if (edge_det) begin
              cnt_q           <= '0;
              pend_valid_q    <= 1'b1;
              pend_interval_q <= cnt_inc;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign evt_valid = (count_q != 3'd0);
  assign pop       = evt_valid && evt_ready;
  assign drop      = pend_valid_q && (count_q == 3'd4) && !pop;
  assign push      = pend_valid_q && !drop;
  assign pe_set    = pend_valid_q && (pend_interval_q != '0)
                     && (pend_interval_q != INT_W'(HALF_PERIOD));

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {pend_ts_q, pend_level_q, pend_interval_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      period_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q    <= count_q + {2'b0, push} - {2'b0, pop};
      period_err <= (period_err & ~clr_err) | pe_set;
      overflow   <= (overflow & ~clr_err) | drop;
    end
  end

  // Outputs are forced to zero when empty so reset values hold without clearing the storage.
  assign head         = mem_q[rd_ptr_q];
  assign evt_ts       = evt_valid ? head[EntryW-1 -: TS_W] : '0;
  assign evt_level    = evt_valid ? head[INT_W] : 1'b0;
  assign evt_interval = evt_valid ? head[INT_W-1:0] : '0;

`ifdef SIGNAL_EDGE_MONITOR_TIMEOUT_EN
  localparam int unsigned NcW = $clog2(TIMEOUT + 1);

  logic [NcW-1:0] quiet_q;
  logic           st_set;

  assign st_set = active && !edge_det && (quiet_q == NcW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quiet_q <= '0;
      stuck   <= 1'b0;
    end else begin
      if (!active || edge_det) begin
        quiet_q <= '0;
      end else if (quiet_q != NcW'(TIMEOUT)) begin
        quiet_q <= quiet_q + NcW'(1);
      end
      stuck <= (stuck & ~clr_err) | st_set;
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_signal_edge_monitor.sv
// Randomized bench for signal_edge_monitor with an event-level reference model and directed
// scenarios whose results are pinned by hand-derived literals.
module tb_signal_edge_monitor;

  localparam int TS_W    = 16;
  localparam int INT_W   = 8;
  localparam int HP      = 5;
  localparam int TIMEOUT = 64;
  localparam int IV_MAX  = (1 << INT_W) - 1;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic             lvl;
    logic [INT_W-1:0] iv;
  } ev_t;

  logic clock, reset, mon_in, enable, clr_err, evt_ready;
  logic evt_valid, evt_level, period_err, overflow, stuck;
  logic [TS_W-1:0]  evt_ts;
  logic [INT_W-1:0] evt_interval;

  signal_edge_monitor #(
    .TS_W(TS_W), .INT_W(INT_W), .HALF_PERIOD(HP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .mon_in(mon_in), .enable(enable), .clr_err(clr_err),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_level(evt_level),
    .evt_interval(evt_interval), .period_err(period_err), .overflow(overflow), .stuck(stuck)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: events are defined by sampled-input history, intervals by cycle distance.
  ev_t             mq[$];
  ev_t             log_q[$];
  bit              samp[$];
  bit              pend_v;
  ev_t             pend;
  bit              en_prev;
  int              last_det, cyc, nocnt;
  logic [TS_W-1:0] mts;
  bit              m_pe, m_ov, m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    samp = '{0, 0, 0};
    pend_v = 0; pend = '0; en_prev = 0;
    last_det = -1; cyc = 0; nocnt = 0; mts = '0;
    m_pe = 0; m_ov = 0; m_st = 0;
  endtask

  task automatic model_tick();
    bit pop, set_pe, set_ov, set_st, active, det;
    int d;
    if (reset) begin
      model_reset();
      return;
    end
    pop = (mq.size() != 0) && evt_ready;
    set_pe = 0; set_ov = 0; set_st = 0;
    if (pend_v) begin
      if (pend.iv != 0 && pend.iv != HP) set_pe = 1;
      if (mq.size() == 4 && !pop) set_ov = 1;
    end
    if (pop) void'(mq.pop_front());
    if (pend_v && !set_ov) mq.push_back(pend);
    active = enable && en_prev;
    det = samp[1] != samp[0];
    pend_v = 0;
    if (!active) begin
      last_det = -1;
      nocnt = 0;
    end else if (det) begin
      pend_v = 1;
      pend.ts = mts;
      pend.lvl = samp[1];
      if (last_det < 0) pend.iv = '0;
      else begin
        d = cyc - last_det;
        pend.iv = INT_W'((d > IV_MAX) ? IV_MAX : d);
      end
      last_det = cyc;
      nocnt = 0;
    end else begin
      nocnt++;
      if (nocnt == TIMEOUT) set_st = 1;
    end
    m_pe = (m_pe && !clr_err) || set_pe;
    m_ov = (m_ov && !clr_err) || set_ov;
`ifdef SIGNAL_EDGE_MONITOR_TIMEOUT_EN
    m_st = (m_st && !clr_err) || set_st;
`else
    m_st = 0;
`endif
    en_prev = enable;
    samp.push_back(mon_in);
    void'(samp.pop_front());
    mts = mts + 1'b1;
    cyc++;
  endtask

  task automatic compare();
    ev_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("evt_valid", evt_valid, mq.size() != 0);
    chk("evt_ts", evt_ts, h.ts);
    chk("evt_level", evt_level, h.lvl);
    chk("evt_interval", evt_interval, h.iv);
    chk("period_err", period_err, m_pe);
    chk("overflow", overflow, m_ov);
    chk("stuck", stuck, m_st);
  endtask

  task automatic step();
    if (evt_valid && evt_ready) log_q.push_back(ev_t'{evt_ts, evt_level, evt_interval});
    @(posedge clock);
    model_tick();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic toggles(input int period, input int count);
    for (int i = 0; i < count; i++) begin
      mon_in = ~mon_in;
      steps(period);
    end
  endtask

  initial begin
    logic [TS_W-1:0] t0;
    int hold;
    int r;
    reset = 1; mon_in = 0; enable = 0; clr_err = 0; evt_ready = 0;
    model_reset();
    steps(50);
    chk("reset_valid", evt_valid, 0);
    chk("reset_ts", evt_ts, 0);
    chk("reset_flags", {period_err, overflow, stuck}, 0);

    // Nominal period, latency from the sampling edge
    reset = 0; enable = 1; evt_ready = 1;
    steps(3);
    log_q.delete();
    mon_in = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("latency", evt_valid, (i == 3));
    end
    step();
    toggles(HP, 8);
    chk("nom_count", log_q.size(), 9);
    if (log_q.size() == 9) begin
      chk("nom_first_iv", log_q[0].iv, 0);
      for (int i = 1; i < 9; i++) begin
        chk("nom_iv", log_q[i].iv, HP);
        chk("nom_ts_step", log_q[i].ts - log_q[i-1].ts, HP);
      end
    end
    chk("nom_period_err", period_err, 0);

    // Wrong period, sticky period_err and its clear
    enable = 0; steps(2); enable = 1; steps(2);
    toggles(7, 3);
    chk("p7_err_set", period_err, 1);
    clr_err = 1; step(); clr_err = 0;
    chk("p7_err_clr", period_err, 0);
    toggles(7, 1);
    chk("p7_err_reset", period_err, 1);
    chk("p7_no_ovf", overflow, 0);

    // Back-pressure: 6 edges into a 4-deep queue
    evt_ready = 0;
    t0 = mts;
    toggles(HP, 6);
    chk("ovf_set", overflow, 1);
    chk("ovf_head_ts", evt_ts, t0 + 16'd2);
    log_q.delete();
    evt_ready = 1;
    steps(6);
    chk("ovf_pop_count", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("ovf_pop_ts", log_q[i].ts, t0 + 16'(2 + HP * i));
    clr_err = 1; step(); clr_err = 0;
    chk("ovf_clr", overflow, 0);

    // Long quiet time: saturating interval and stuck
    log_q.delete();
    steps(300);
`ifdef SIGNAL_EDGE_MONITOR_TIMEOUT_EN
    chk("stuck_quiet", stuck, 1);
`else
    chk("stuck_quiet", stuck, 0);
`endif
    toggles(HP, 1);
    chk("sat_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("sat_iv", log_q[0].iv, IV_MAX);

    // Edges while disabled are ignored; re-enable restarts with interval 0
    clr_err = 1; step(); clr_err = 0;
    enable = 0;
    log_q.delete();
    toggles(HP, 4);
    chk("dis_none", log_q.size(), 0);
    enable = 1; steps(3);
    toggles(HP, 1);
    chk("reen_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("reen_iv", log_q[0].iv, 0);

    // Asynchronous reset with two queued events
    evt_ready = 0;
    toggles(HP, 2);
    chk("q2_valid", evt_valid, 1);
    #3 reset = 1;
    #1;
    chk("async_valid", evt_valid, 0);
    chk("async_ts", evt_ts, 0);
    steps(2);
    reset = 0;
    steps(2);

    // Randomized traffic
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        mon_in = ~mon_in;
        r = $urandom_range(0, 3);
        hold = (r < 2) ? HP : ((r == 2) ? 7 : $urandom_range(1, 12));
      end
      hold--;
      evt_ready = ($urandom_range(0, 9) < 6);
      clr_err = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
